mux_sel_sequencer: RTL
======================

// Module: mux_sel_sequencer
// PURPOSE
//  Upstream control stage for a 4:1 mux. Holds a 4-bit data word on mux_i and steps mux_sel
//  through the enabled channels in ascending order, dwelling DWELL cycles on each.
//  On the last dwell cycle of a channel it samples the mux output (mux_y) back into result.
//  This makes a start/busy/done scan engine: the downstream mux is read out one channel at a time.
// PARAMETERS
//  DWELL  default 1  cycles spent on each enabled channel; legal range 1..2**CNT_W-1
//  CNT_W  default 8  width of the dwell counter
// PORTS
//  clk       in   1  rising-edge clock
//  rst       in   1  asynchronous, active-high reset
//  start     in   1  request a scan; sampled only in IDLE
//  data_in   in   4  word to present to the mux; latched when start is accepted
//  ch_en     in   4  channel enable mask; latched when start is accepted
//  mux_y     in   1  output of the downstream 4:1 mux
//  mux_i     out  4  registered data word driving the mux I inputs
//  mux_sel   out  2  registered channel select driving the mux sel input
//  busy      out  1  high from the cycle after start acceptance through the DONE cycle
//  done      out  1  one-cycle pulse in the DONE state
//  result    out  4  sampled mux_y per channel; bits for disabled channels are 0
// BEHAVIOUR
//  Reset (asynchronous, any time): state=IDLE; mux_i=0, mux_sel=0, busy=0, done=0, result=0,
//    dwell counter=0, latched mask=0. A reset asserted mid-scan aborts the scan with no done pulse.
//  FSM has three states: IDLE, SCAN, DONE. All outputs are registered.
//  IDLE: busy=0, done=0.
//    - When start=1, the block latches data_in into mux_i and ch_en into en_r, and clears result.
//    - If ch_en!=0: mux_sel becomes the lowest set bit index, cnt becomes 0, and the next state is SCAN.
//    - If ch_en==0: the next state is DONE directly. result stays 0 and mux_sel is unchanged.
//  SCAN: busy=1; mux_sel and mux_i are held stable for the full dwell.
//    - Each cycle: if cnt<DWELL-1 then cnt++.
//    - Otherwise (last dwell cycle):
//      - result[mux_sel] <= mux_y, and cnt <= 0.
//      - If a higher enabled channel exists, mux_sel moves to the next higher set bit of en_r.
//      - Otherwise the next state is DONE and mux_sel holds its value.
//    - No wrap-around: channel 3 is always the final candidate.
//  DONE: busy=1, done=1 for exactly one cycle. result is final. The next state is always IDLE.
//  start is ignored while in SCAN or DONE; it is not queued. start in IDLE on the cycle right
//    after DONE is accepted normally.
//  mux_i, mux_sel and result hold their values in IDLE until the next accepted start or reset.
//  Latency: with start accepted in cycle 0 and k enabled channels, done=1 in cycle
//    1 + k*DWELL (cycle 1 when k=0).
//  mux_y must be stable combinationally from mux_i/mux_sel. It is sampled at the clock edge that
//    ends the last dwell cycle, so the minimum settling time is one cycle (DWELL=1).
// TESTING
//  Bench ties mux_y to a behavioural 4:1 mux: y = mux_i[mux_sel].
//  1. Reset check: assert rst mid-cycle with no clock edge -> all outputs read 0 immediately;
//     state is IDLE.
//  2. DWELL=1, data_in=4'b1010, ch_en=4'b1111, start pulsed in cycle 0 ->
//     mux_sel=0,1,2,3 in cycles 1-4; done=1 in cycle 5; result=4'b1010.
//  3. DWELL=1, data_in=4'b1111, ch_en=4'b0101 -> mux_sel=0 then 2; done=1 in cycle 3;
//     result=4'b0101.
//  4. ch_en=4'b0000, start pulsed -> done=1 in cycle 1, busy=1 for that cycle only, result=0.
//  5. DWELL=3, ch_en=4'b1000, data_in=4'b1000 -> mux_sel=3 held for cycles 1-3; done in
//     cycle 4; result=4'b1000. A start pulsed in cycle 2 is ignored, with no second scan.
//  6. Reset mid-scan: assert rst in cycle 2 of test 2 -> outputs are 0 at once and no done pulse.
//     After release, a new start with data 4'b0110 gives result=4'b0110.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// Scan engine for a downstream 4:1 mux: presents a latched data word, steps the select
// through the enabled channels in ascending order and samples the mux output per channel.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last scan
// SCAN  | dwelling on the channel in mux_sel, sampling mux_y on its last dwell cycle
// DONE  | one-cycle completion pulse, result is final
module mux_sel_sequencer #(
    parameter int DWELL = 1,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] data_in,
    input  logic [3:0] ch_en,
    input  logic       mux_y,
    output logic [3:0] mux_i,
    output logic [1:0] mux_sel,
    output logic       busy,
    output logic       done,
    output logic [3:0] result
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [3:0]       mux_i_q, mux_i_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       en_q, en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [1:0]       first_sel;
    logic [1:0]       next_sel;
    logic             has_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mux_i_q  <= '0;
            sel_q    <= '0;
            en_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mux_i_q  <= mux_i_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mux_i_d   = mux_i_q;
        sel_d     = sel_q;
        en_d      = en_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        first_sel = 2'd0;
        next_sel  = sel_q;
        has_next  = 1'b0;

        // Descending scans so the last hit is the lowest qualifying index.
        for (int j = 3; j >= 0; j--) begin
            if (ch_en[j]) first_sel = 2'(j);
            if (en_q[j] && (j > int'(sel_q))) begin
                next_sel = 2'(j);
                has_next = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    mux_i_d  = data_in;
                    en_d     = ch_en;
                    result_d = '0;
                    busy_d   = 1'b1;
                    if (ch_en != 4'b0000) begin
                        sel_d   = first_sel;
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                busy_d = 1'b1;
                if (cnt_q < LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    result_d[sel_q] = mux_y;
                    cnt_d           = '0;
                    if (has_next) begin
                        sel_d = next_sel;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mux_i   = mux_i_q;
    assign mux_sel = sel_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule
